// File: rtl/shift_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_pkg
// Description : Shared encodings for the universal shift register: manual
//               operation codes, burst direction codes and burst FSM states.
//               The manual operation codes double as the per-stage
//               next-value select.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_reg_pkg;

    // Manual operation / per-stage next-value select
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Burst direction
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Burst engine states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_stage
// Description : One W-bit stage of the universal shift register. It is a
//               register with an asynchronous clear and a 4-way next-value
//               mux: hold, take the neighbour below, take the neighbour
//               above, or take the parallel input.
// Revision    : 1.0 - initial release
// Ports       :
//   clk        - rising-edge clock
//   asyn_clr   - asynchronous active-high clear
//   sel        - next-value select (MODE_* encoding)
//   from_below - value of stage i-1 (or serial-in for stage 0)
//   from_above - value of stage i+1 (or serial-in for stage N-1)
//   par_in     - parallel load value
//   q          - registered stage value
// ============================================================================
module shift_stage
    import shift_reg_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         asyn_clr,
    input  logic [1:0]   sel,
    input  logic [W-1:0] from_below,
    input  logic [W-1:0] from_above,
    input  logic [W-1:0] par_in,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;
    logic [W-1:0] w_next;

    always_comb begin
        w_next = r_q;
        case (sel)
            MODE_UP:   w_next = from_below;
            MODE_DOWN: w_next = from_above;
            MODE_LOAD: w_next = par_in;
            default:   w_next = r_q;
        endcase
    end

    always_ff @(posedge clk or posedge asyn_clr) begin
        if (asyn_clr) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : univ_shift_reg
// Description : N-stage, W-bit universal shift register with hold, shift
//               up, shift down and parallel load, plus a self-timed burst
//               engine that shifts LEN times in a latched direction.
//               Optional macro UNIV_SHIFT_REG_ROTATE_EN adds input 'rot',
//               which makes any shift take its serial input from the
//               opposite end of the register (rotate).
// Revision    : 1.0 - initial release
// Ports       :
//   clk       - rising-edge clock
//   asyn_clr  - asynchronous active-high clear
//   mode      - manual op: 00 hold, 01 up, 10 down, 11 parallel load
//   sin_lo    - serial in to stage 0 on shift up
//   sin_hi    - serial in to stage N-1 on shift down
//   pdata_in  - parallel load data, stage i at [i*W +: W]
//   start     - burst request (honoured only when idle)
//   dir       - burst direction: 0 up, 1 down
//   len       - burst shift count (0 gives an immediate done)
//   rot       - rotate enable (only with UNIV_SHIFT_REG_ROTATE_EN)
//   pdata_out - all stages, same packing as pdata_in
//   sout_hi   - stage N-1
//   sout_lo   - stage 0
//   busy      - burst in progress
//   done      - one-cycle burst-complete pulse
// ============================================================================
module univ_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int N     = 8,
    parameter int W     = 1,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             asyn_clr,
    input  logic [1:0]       mode,
    input  logic [W-1:0]     sin_lo,
    input  logic [W-1:0]     sin_hi,
    input  logic [N*W-1:0]   pdata_in,
    input  logic             start,
    input  logic             dir,
    input  logic [LEN_W-1:0] len,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    input  logic             rot,
`endif
    output logic [N*W-1:0]   pdata_out,
    output logic [W-1:0]     sout_hi,
    output logic [W-1:0]     sout_lo,
    output logic             busy,
    output logic             done
);

    logic [W-1:0]     w_stage [N];
    logic [W-1:0]     w_below [N];
    logic [W-1:0]     w_above [N];
    logic [W-1:0]     w_ser_lo;
    logic [W-1:0]     w_ser_hi;
    logic [1:0]       w_sel;

    state_t           r_state;
    logic [LEN_W-1:0] r_cnt;
    logic             r_dir;
    logic             r_busy;
    logic             r_done;

    // Serial inputs at the two ends; rotation wraps the far end around.
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    assign w_ser_lo = rot ? w_stage[N-1] : sin_lo;
    assign w_ser_hi = rot ? w_stage[0]   : sin_hi;
`else
    assign w_ser_lo = sin_lo;
    assign w_ser_hi = sin_hi;
`endif

    // Common stage select. A start accepted in IDLE freezes the stages for
    // that edge; while a burst runs, mode is ignored.
    always_comb begin
        w_sel = MODE_HOLD;
        if (r_state == ST_RUN) begin
            w_sel = (r_dir == DIR_DOWN) ? MODE_DOWN : MODE_UP;
        end else if (!start) begin
            w_sel = mode;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_stage
        if (i == 0) begin : g_bottom
            assign w_below[i] = w_ser_lo;
        end else begin : g_from_below
            assign w_below[i] = w_stage[i-1];
        end

        if (i == N - 1) begin : g_top
            assign w_above[i] = w_ser_hi;
        end else begin : g_from_above
            assign w_above[i] = w_stage[i+1];
        end

        shift_stage #(
            .W (W)
        ) u_stage (
            .clk        (clk),
            .asyn_clr   (asyn_clr),
            .sel        (w_sel),
            .from_below (w_below[i]),
            .from_above (w_above[i]),
            .par_in     (pdata_in[i*W +: W]),
            .q          (w_stage[i])
        );

        assign pdata_out[i*W +: W] = w_stage[i];
    end

    // Burst engine: counter holds the number of shifts still to perform.
    always_ff @(posedge clk or posedge asyn_clr) begin
        if (asyn_clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dir   <= DIR_UP;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        if (len != '0) begin
                            r_state <= ST_RUN;
                            r_cnt   <= len;
                            r_dir   <= dir;
                            r_busy  <= 1'b1;
                        end else begin
                            // Zero-length burst completes at once.
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - LEN_W'(1);
                    if (r_cnt == LEN_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign sout_hi = w_stage[N-1];
    assign sout_lo = w_stage[0];
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_univ_shift_reg
// Description : Self-checking bench for univ_shift_reg. A driver applies
//               directed and random stimulus on the falling edge, advances
//               a queue-based reference model by one clock and queues the
//               expected outputs; a monitor pops and compares after each
//               rising edge (or right after a mid-cycle clear).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;
    import shift_reg_pkg::*;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
    localparam int N = 8;
    localparam int W = 1;
`else
    localparam int N = 4;
    localparam int W = 4;
`endif
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             asyn_clr;
    logic [1:0]       mode;
    logic [W-1:0]     sin_lo;
    logic [W-1:0]     sin_hi;
    logic [N*W-1:0]   pdata_in;
    logic             start;
    logic             dir;
    logic [LEN_W-1:0] len;
    logic             rot;
    logic [N*W-1:0]   pdata_out;
    logic [W-1:0]     sout_hi;
    logic [W-1:0]     sout_lo;
    logic             busy;
    logic             done;

    univ_shift_reg #(
        .N     (N),
        .W     (W),
        .LEN_W (LEN_W)
    ) dut (
        .clk       (clk),
        .asyn_clr  (asyn_clr),
        .mode      (mode),
        .sin_lo    (sin_lo),
        .sin_hi    (sin_hi),
        .pdata_in  (pdata_in),
        .start     (start),
        .dir       (dir),
        .len       (len),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        .rot       (rot),
`endif
        .pdata_out (pdata_out),
        .sout_hi   (sout_hi),
        .sout_lo   (sout_lo),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] pd;
        logic           busy;
        logic           done;
        string          name;
    } exp_t;

    exp_t sb[$];
    event ev_chk;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    // ---------------- reference model ----------------
    logic [W-1:0] m_q[$];      // m_q[i] is stage i
    int           m_left;      // shifts still owed by a running burst
    logic         m_dir;
    logic         m_done;

    function automatic void m_reset();
        m_q.delete();
        for (int i = 0; i < N; i++) m_q.push_back('0);
        m_left = 0;
        m_dir  = 1'b0;
        m_done = 1'b0;
    endfunction

    function automatic void m_shift(logic down);
        logic [W-1:0] s;
        if (!down) begin
            s = (rot === 1'b1) ? m_q[N-1] : sin_lo;
            m_q.push_front(s);
            void'(m_q.pop_back());
        end else begin
            s = (rot === 1'b1) ? m_q[0] : sin_hi;
            m_q.push_back(s);
            void'(m_q.pop_front());
        end
    endfunction

    // Advance the model across one rising edge using the current inputs.
    function automatic void m_edge();
        if (m_left == 0) begin
            m_done = 1'b0;
            if (start) begin
                if (len == 0) m_done = 1'b1;
                else begin
                    m_left = int'(len);
                    m_dir  = dir;
                end
            end else begin
                case (mode)
                    MODE_UP:   m_shift(1'b0);
                    MODE_DOWN: m_shift(1'b1);
                    MODE_LOAD: for (int i = 0; i < N; i++) m_q[i] = pdata_in[i*W +: W];
                    default:   ;
                endcase
            end
        end else begin
            m_shift(m_dir);
            m_left = m_left - 1;
            m_done = (m_left == 0);
        end
    endfunction

    function automatic void push_exp(string nm);
        exp_t e;
        for (int i = 0; i < N; i++) e.pd[i*W +: W] = m_q[i];
        e.busy = (m_left != 0);
        e.done = m_done;
        e.name = nm;
        sb.push_back(e);
    endfunction

    // ---------------- monitor ----------------
    task automatic check(exp_t e);
        logic [W-1:0] exp_lo;
        logic [W-1:0] exp_hi;
        exp_lo = e.pd[W-1:0];
        exp_hi = e.pd[N*W-1 -: W];
        chk_cnt++;
        if (pdata_out !== e.pd || busy !== e.busy || done !== e.done ||
            sout_lo !== exp_lo || sout_hi !== exp_hi) begin
            $display("FAIL %s: got pdata_out=%h busy=%b done=%b sout_lo=%h sout_hi=%h, want pdata_out=%h busy=%b done=%b sout_lo=%h sout_hi=%h",
                     e.name, pdata_out, busy, done, sout_lo, sout_hi,
                     e.pd, e.busy, e.done, exp_lo, exp_hi);
        end else begin
            pass_cnt++;
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk or ev_chk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic set_idle();
        mode     = MODE_HOLD;
        sin_lo   = '0;
        sin_hi   = '0;
        pdata_in = '0;
        start    = 1'b0;
        dir      = 1'b0;
        len      = '0;
    endtask

    task automatic drive(input logic [1:0] m, input logic [W-1:0] slo,
                         input logic [W-1:0] shi, input logic [N*W-1:0] pd,
                         input logic st, input logic d,
                         input logic [LEN_W-1:0] l, input string nm);
        @(negedge clk);
        mode     = m;
        sin_lo   = slo;
        sin_hi   = shi;
        pdata_in = pd;
        start    = st;
        dir      = d;
        len      = l;
        m_edge();
        push_exp(nm);
    endtask

    // Mid-cycle clear: outputs must be zero before the next rising edge.
    task automatic pulse_reset(input string nm);
        @(negedge clk);
        set_idle();
        #1;
        asyn_clr = 1'b1;
        m_reset();
        push_exp(nm);
        -> ev_chk;
        #2;
        asyn_clr = 1'b0;
    endtask

    initial begin
        asyn_clr = 1'b1;
        rot      = 1'b0;
        set_idle();
        m_reset();
        #12;
        asyn_clr = 1'b0;

        pulse_reset("reset_state");

`ifdef UNIV_SHIFT_REG_ROTATE_EN
        drive(MODE_LOAD, '0, '0, 8'b0000_0001, 1'b0, 1'b0, 4'd0, "rot_load");
        rot = 1'b1;
        drive(MODE_HOLD, 1'b1, 1'b1, '0, 1'b1, DIR_UP, 4'd8, "rot_start");
        for (int i = 1; i <= 8; i++)
            drive(MODE_LOAD, 1'b1, 1'b1, '1, 1'b0, 1'b0, 4'd0, $sformatf("rot_shift%0d", i));
        drive(MODE_HOLD, '0, '0, '0, 1'b0, 1'b0, 4'd0, "rot_after");
        drive(MODE_DOWN, '0, '0, '0, 1'b0, 1'b0, 4'd0, "rot_manual_down");
        rot = 1'b0;
`else
        // reset then load
        drive(MODE_LOAD, '0, '0, 16'h4321, 1'b0, 1'b0, 4'd0, "load");
        pulse_reset("clr_mid_cycle");
        drive(MODE_HOLD, '0, '0, 16'h9999, 1'b0, 1'b0, 4'd0, "hold_after_clr");
        drive(MODE_LOAD, '0, '0, 16'h4321, 1'b0, 1'b0, 4'd0, "load_4321");
        // manual shifts
        drive(MODE_UP,   4'hA, 4'h0, '0, 1'b0, 1'b0, 4'd0, "shift_up");
        drive(MODE_DOWN, 4'h0, 4'hF, '0, 1'b0, 1'b0, 4'd0, "shift_down");
        // burst up by 3 with mode=load toggling
        drive(MODE_LOAD, '0, '0, 16'h4321, 1'b0, 1'b0, 4'd0, "burst_load");
        drive(MODE_LOAD, '0, '0, 16'hEEEE, 1'b1, DIR_UP, 4'd3, "burst_start");
        drive(MODE_LOAD, '0, '0, 16'hFFFF, 1'b0, 1'b0, 4'd0, "burst_s1");
        drive(MODE_HOLD, '0, '0, 16'hFFFF, 1'b0, 1'b0, 4'd0, "burst_s2");
        drive(MODE_LOAD, '0, '0, 16'hFFFF, 1'b0, 1'b0, 4'd0, "burst_s3_done");
        drive(MODE_HOLD, '0, '0, '0, 1'b0, 1'b0, 4'd0, "burst_after");
        // zero-length burst
        drive(MODE_HOLD, 4'h7, 4'h7, '0, 1'b1, DIR_UP, 4'd0, "len0_done");
        drive(MODE_HOLD, '0, '0, '0, 1'b0, 1'b0, 4'd0, "len0_after");
        // back-to-back bursts, start while busy ignored
        drive(MODE_HOLD, 4'h5, '0, '0, 1'b1, DIR_UP, 4'd2, "b2b_start1");
        drive(MODE_LOAD, 4'h5, '0, '1, 1'b1, DIR_DOWN, 4'd7, "start_while_busy");
        drive(MODE_HOLD, 4'h6, '0, '0, 1'b0, 1'b0, 4'd0, "b2b_done1");
        drive(MODE_HOLD, '0, 4'h9, '0, 1'b1, DIR_DOWN, 4'd1, "b2b_start2");
        drive(MODE_HOLD, '0, 4'h9, '0, 1'b0, 1'b0, 4'd0, "b2b_done2");
        drive(MODE_HOLD, '0, '0, '0, 1'b0, 1'b0, 4'd0, "b2b_after");
        // clear in the middle of a long burst
        drive(MODE_LOAD, '0, '0, 16'hABCD, 1'b0, 1'b0, 4'd0, "long_load");
        drive(MODE_HOLD, '0, 4'h3, '0, 1'b1, DIR_DOWN, 4'd15, "long_start");
        for (int i = 1; i <= 5; i++)
            drive(MODE_HOLD, '0, 4'h3, '0, 1'b0, 1'b0, 4'd0, $sformatf("long_shift%0d", i));
        pulse_reset("clr_mid_burst");
        for (int i = 0; i < 3; i++)
            drive(MODE_HOLD, '0, '0, '0, 1'b0, 1'b0, 4'd0, $sformatf("no_done_after_clr%0d", i));
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                pulse_reset($sformatf("rnd_clr%0d", i));
            end else begin
`ifdef UNIV_SHIFT_REG_ROTATE_EN
                rot = 1'($urandom_range(0, 1));
`endif
                drive(2'($urandom_range(0, 3)), W'($urandom), W'($urandom),
                      (N*W)'($urandom), ($urandom_range(0, 7) == 0),
                      1'($urandom_range(0, 1)), LEN_W'($urandom_range(0, 15)),
                      $sformatf("rnd%0d", i));
            end
        end

        @(negedge clk);
        set_idle();
        rot = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        #2;
        if (sb.size() != 0) begin
            chk_cnt++;
            $display("FAIL drain: %0d expected responses left unchecked, want 0", sb.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
